// File: rtl/rv32_fetch_buffered.sv
// Decoupled RV32 fetch: req/gnt + in-order response memory port, credit-limited
// fetch buffer, and a decode pipeline register with flush/stall.
module rv32_fetch_buffered #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pc_source_i,
  input  logic [31:0] pc_target_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  fb_entry_t      fifo_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [OW-1:0]  out_q, disc_q;
  logic [31:0]    fetch_pc_q, resp_pc_q;
  logic [31:0]    credit_used;
  logic           accept, drop, push, pop, full;
  fb_entry_t      head;

  // In-flight responses that will be kept still need a slot, so they count
  // against the buffer; responses marked for discard do not.
  assign credit_used = 32'(cnt_q) + 32'(out_q) - 32'(disc_q);
  assign imem_req_o  = !pc_source_i && (32'(out_q) < MAX_OUTSTANDING) && (credit_used < DEPTH);
  assign imem_addr_o = fetch_pc_q;

  assign accept = imem_req_o && imem_gnt_i;
  assign drop   = imem_rvalid_i && (pc_source_i || (disc_q != '0));
  assign push   = imem_rvalid_i && !drop;
  assign pop    = !flush_d_i && !stall_d_i && !pc_source_i && (cnt_q != '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign head   = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      out_q <= out_q + OW'(accept) - OW'(imem_rvalid_i);
      if (pc_source_i) begin
        fetch_pc_q <= pc_target_i;
        resp_pc_q  <= pc_target_i;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        // a response landing in the redirect cycle is already dropped
        disc_q     <= out_q - OW'(imem_rvalid_i);
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (drop)   disc_q     <= disc_q - OW'(1);
        if (push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
          wr_ptr_q  <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_rdata_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      pc_o      <= '0;
      pc_next_o <= '0;
    end else if (flush_d_i) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      pc_o      <= '0;
      pc_next_o <= '0;
    end else if (!stall_d_i) begin
      if (pop) begin
        valid_o   <= 1'b1;
        instr_o   <= head.instr;
        pc_o      <= head.pc;
        pc_next_o <= head.pc + 32'd4;
      end else begin
        valid_o   <= 1'b0;
        instr_o   <= '0;
        pc_o      <= '0;
        pc_next_o <= '0;
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && full));
  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(imem_rvalid_i && out_q == '0));
  a_disc_le_out:  assert property (@(posedge clk_i) disable iff (!rst_n_i) disc_q <= out_q);

endmodule
